// File: rtl/mix_columns_serial_pkg.sv
// Shared AES model types and constants used by the round datapath stages.
package aes_model_pack;

   localparam int COLUMN_SIZE_IN_BYTES = 4;
   localparam int STATE_SIZE_IN_BYTES  = 16;
   localparam int NUM_COLUMNS          = STATE_SIZE_IN_BYTES / COLUMN_SIZE_IN_BYTES;
   localparam int COL_IDX_W            = $clog2(NUM_COLUMNS);

   // Within a column, byte index 3 is row 0 (first byte of a packed literal).
   typedef logic [COLUMN_SIZE_IN_BYTES-1:0][7:0] column_t;

   // Column 0 occupies bits [31:0] and is the first column processed.
   typedef column_t [NUM_COLUMNS-1:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MIX  = 2'd1,
      ST_OUT  = 2'd2
   } mix_state_e;

endpackage

// File: rtl/mix_columns_serial_mix_one_column.sv
// Combinational MixColumns of a single 4-byte column over GF(2^8).
module mix_one_column
   import aes_model_pack::*;
(
   input  column_t column,
   output column_t mixed_column
);

   // Multiply by x (i.e. by 2) modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] x0, x1, x2, x3;

   // Row bytes of the incoming column, row 0 first.
   assign a0 = column[3];
   assign a1 = column[2];
   assign a2 = column[1];
   assign a3 = column[0];

   assign x0 = xtime(a0);
   assign x1 = xtime(a1);
   assign x2 = xtime(a2);
   assign x3 = xtime(a3);

   // Circulant matrix {2,3,1,1}: 3*a is written as xtime(a)^a.
   always_comb begin
      mixed_column[3] = x0 ^ x1 ^ a1 ^ a2 ^ a3;
      mixed_column[2] = a0 ^ x1 ^ x2 ^ a2 ^ a3;
      mixed_column[1] = a0 ^ a1 ^ x2 ^ x3 ^ a3;
      mixed_column[0] = x0 ^ a0 ^ a1 ^ a2 ^ x3;
   end

endmodule

// File: rtl/mix_columns_serial.sv
// Iterative MixColumns stage: one column per cycle through a shared
// mix_one_column, mixed in place, then held for the downstream handshake.
module mix_columns_serial
   import aes_model_pack::*;
#(
   parameter int COLUMNS = COLUMN_SIZE_IN_BYTES
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   in_valid,
   output logic   in_ready,
   input  state_t in_state,
   input  logic   in_last_round,
   output logic   out_valid,
   input  logic   out_ready,
   output state_t out_state
);

   localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(COLUMNS - 1);

   mix_state_e             state_q, state_d;
   logic [COL_IDX_W-1:0]   col_idx_q, col_idx_d;
   state_t                 buf_q, buf_d;
   column_t                mix_in;
   column_t                mix_out;

   assign mix_in = buf_q[col_idx_q];

   mix_one_column u_mix_one_column (
      .column       (mix_in),
      .mixed_column (mix_out)
   );

   // Next-state, in-place column write-back and handshake outputs.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer latches.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' so later statements see
      // the updated value; the flops below use non-blocking '<='.
      state_d   = state_q;
      col_idx_d = col_idx_q;
      buf_d     = buf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end

         ST_MIX: begin
            buf_d[col_idx_q] = mix_out;
            if (col_idx_q == LAST_COL) begin
               col_idx_d = '0;
               state_d   = ST_OUT;
            end else begin
               col_idx_d = col_idx_q + 1'b1;
            end
         end

         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            col_idx_d = '0;
         end
      endcase

      // A new state can be taken from IDLE, or from OUT in the same cycle
      // the held result is consumed; the last-round flag skips the mix.
      if (in_valid && in_ready) begin
         buf_d     = in_state;
         col_idx_d = '0;
         state_d   = in_last_round ? ST_OUT : ST_MIX;
      end
   end

   // State, column counter and state buffer registers.
   // NOTE: buf_q is reset too, so out_state reads all-zero after reset and a
   // partially mixed state can never leak into the next transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         col_idx_q <= '0;
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_idx_q <= col_idx_d;
         buf_q     <= buf_d;
      end
   end

   assign out_state = buf_q;

endmodule
